// File: rtl/msx_slot_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : msx_slot_io_bridge
// Description : MSX slot I/O window decoder bridging Z80 port accesses onto a
//               valid/ready VDP request bus. Optional CPU wait-state stretching
//               is enabled by defining SLOT_WAIT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module msx_slot_io_bridge #(
    parameter logic [7:0]  IO_BASE      = 8'h88,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       slot_iorq_n,
    input  logic       slot_rd_n,
    input  logic       slot_wr_n,
    input  logic [7:0] slot_a,
    input  logic [7:0] slot_d_in,
    output logic [7:0] slot_d_out,
    output logic       slot_data_dir,
    output logic       slot_wait,
    output logic       bus_valid,
    input  logic       bus_ready,
    output logic       bus_write,
    output logic [1:0] bus_address,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       bus_rdata_en
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_REQ   = 3'd1,
        S_RD_REQ   = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_HOLD  = 3'd4,
        S_END_WAIT = 3'd5
    } state_t;

    // Timeout fires on the last permitted cycle so the request is visible for WAIT_TIMEOUT clocks
    localparam logic [9:0] c_tmo_last = 10'(WAIT_TIMEOUT - 1);

    state_t     r_state;
    logic [9:0] r_tmo_cnt;
    logic [1:0] r_iorq_sync;
    logic [1:0] r_rd_sync;
    logic [1:0] r_wr_sync;

    logic w_iorq_n;
    logic w_rd_n;
    logic w_wr_n;
    logic w_hit;
    logic w_start;
    logic w_tmo;
    logic w_busy;

    assign w_iorq_n = r_iorq_sync[1];
    assign w_rd_n   = r_rd_sync[1];
    assign w_wr_n   = r_wr_sync[1];
    assign w_hit    = (slot_a[7:2] == IO_BASE[7:2]);
    assign w_start  = (r_state == S_IDLE) && !w_iorq_n && (!w_wr_n || !w_rd_n) && w_hit;
    assign w_tmo    = (r_tmo_cnt == c_tmo_last);
    assign w_busy   = (r_state == S_WR_REQ) || (r_state == S_RD_REQ) || (r_state == S_RD_WAIT);

    assign slot_data_dir = !w_rd_n &&
        ((r_state == S_RD_REQ) || (r_state == S_RD_WAIT) || (r_state == S_RD_HOLD));

`ifdef SLOT_WAIT_EN
    assign slot_wait = w_start || w_busy;
`else
    assign slot_wait = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_iorq_sync <= 2'b11;
            r_rd_sync   <= 2'b11;
            r_wr_sync   <= 2'b11;
        end else begin
            r_iorq_sync <= {r_iorq_sync[0], slot_iorq_n};
            r_rd_sync   <= {r_rd_sync[0], slot_rd_n};
            r_wr_sync   <= {r_wr_sync[0], slot_wr_n};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tmo_cnt   <= '0;
            bus_valid   <= 1'b0;
            bus_write   <= 1'b0;
            bus_address <= 2'd0;
            bus_wdata   <= 8'd0;
            slot_d_out  <= 8'hFF;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_tmo_cnt   <= '0;
                        bus_valid   <= 1'b1;
                        bus_address <= slot_a[1:0];
                        // Both strobes low is treated as a write
                        if (!w_wr_n) begin
                            bus_write <= 1'b1;
                            bus_wdata <= slot_d_in;
                            r_state   <= S_WR_REQ;
                        end else begin
                            bus_write  <= 1'b0;
                            slot_d_out <= 8'hFF;
                            r_state    <= S_RD_REQ;
                        end
                    end
                end
                S_WR_REQ: begin
                    if (bus_ready || w_tmo) begin
                        bus_valid <= 1'b0;
                        r_tmo_cnt <= '0;
                        r_state   <= S_END_WAIT;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 10'd1;
                    end
                end
                S_RD_REQ: begin
                    if (bus_ready) begin
                        bus_valid <= 1'b0;
                        r_tmo_cnt <= '0;
                        if (bus_rdata_en) begin
                            slot_d_out <= bus_rdata;
                            r_state    <= S_RD_HOLD;
                        end else begin
                            r_state <= S_RD_WAIT;
                        end
                    end else if (w_tmo) begin
                        bus_valid  <= 1'b0;
                        r_tmo_cnt  <= '0;
                        slot_d_out <= 8'hFF;
                        r_state    <= S_RD_HOLD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 10'd1;
                    end
                end
                S_RD_WAIT: begin
                    if (bus_rdata_en) begin
                        slot_d_out <= bus_rdata;
                        r_tmo_cnt  <= '0;
                        r_state    <= S_RD_HOLD;
                    end else if (w_tmo) begin
                        slot_d_out <= 8'hFF;
                        r_tmo_cnt  <= '0;
                        r_state    <= S_RD_HOLD;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 10'd1;
                    end
                end
                S_RD_HOLD, S_END_WAIT: begin
                    // Rearm only once /IORQ has returned high: one request per CPU cycle
                    if (w_iorq_n) begin
                        r_tmo_cnt <= '0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_tmo_cnt <= '0;
                    bus_valid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_msx_slot_io_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_msx_slot_io_bridge
// Description : Self-checking bench for msx_slot_io_bridge with a VDP responder
//               and a transaction-level expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msx_slot_io_bridge;

    localparam logic [7:0] c_io_base = 8'h88;
    localparam int         c_timeout = 16;
`ifdef SLOT_WAIT_EN
    localparam logic       c_wait_en = 1'b1;
`else
    localparam logic       c_wait_en = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       slot_iorq_n = 1'b1;
    logic       slot_rd_n = 1'b1;
    logic       slot_wr_n = 1'b1;
    logic [7:0] slot_a = 8'h00;
    logic [7:0] slot_d_in = 8'h00;
    logic [7:0] slot_d_out;
    logic       slot_data_dir;
    logic       slot_wait;
    logic       bus_valid;
    logic       bus_ready = 1'b0;
    logic       bus_write;
    logic [1:0] bus_address;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata = 8'h00;
    logic       bus_rdata_en = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          cfg_rdly = 0;
    int          cfg_ddly = 0;
    logic [7:0]  cfg_rdata = 8'h00;
    int          valid_cycles = 0;
    int          pulses = 0;
    int          dir_cycles = 0;
    int          wait_cycles = 0;
    logic        prev_valid = 1'b0;
    int          vcnt = 0;
    int          rd_cnt = -1;
    logic [10:0] hs_q[$];

    msx_slot_io_bridge #(
        .IO_BASE      (c_io_base),
        .WAIT_TIMEOUT (c_timeout)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .slot_iorq_n   (slot_iorq_n),
        .slot_rd_n     (slot_rd_n),
        .slot_wr_n     (slot_wr_n),
        .slot_a        (slot_a),
        .slot_d_in     (slot_d_in),
        .slot_d_out    (slot_d_out),
        .slot_data_dir (slot_data_dir),
        .slot_wait     (slot_wait),
        .bus_valid     (bus_valid),
        .bus_ready     (bus_ready),
        .bus_write     (bus_write),
        .bus_address   (bus_address),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_rdata_en  (bus_rdata_en)
    );

    always #5 clk = ~clk;

    // VDP responder: ready after cfg_rdly stalled cycles, read data cfg_ddly clocks after the handshake
    initial begin
        forever begin
            @(negedge clk);
            if (bus_valid) valid_cycles++;
            if (bus_valid && !prev_valid) pulses++;
            prev_valid = bus_valid;
            if (slot_data_dir) dir_cycles++;
            if (slot_wait) wait_cycles++;
            bus_ready    = 1'b0;
            bus_rdata_en = 1'b0;
            if (reset) begin
                vcnt   = 0;
                rd_cnt = -1;
            end else begin
                if (rd_cnt == 0) begin
                    bus_rdata_en = 1'b1;
                    bus_rdata    = cfg_rdata;
                    rd_cnt       = -1;
                end else if (rd_cnt > 0) begin
                    rd_cnt--;
                end
                if (bus_valid) begin
                    vcnt++;
                    if (vcnt > cfg_rdly) begin
                        bus_ready = 1'b1;
                        vcnt      = 0;
                        hs_q.push_back({bus_write, bus_address, bus_wdata});
                        if (!bus_write) begin
                            if (cfg_ddly == 0) begin
                                bus_rdata_en = 1'b1;
                                bus_rdata    = cfg_rdata;
                            end else begin
                                rd_cnt = cfg_ddly - 1;
                            end
                        end
                    end
                end else begin
                    vcnt = 0;
                end
            end
        end
    end

    // mode: 0 = read, 1 = write, 2 = both strobes low
    task automatic cpu_begin(input logic [7:0] a, input int mode, input logic [7:0] d);
        @(negedge clk);
        slot_a      = a;
        slot_d_in   = d;
        slot_iorq_n = 1'b0;
        slot_wr_n   = (mode != 0) ? 1'b0 : 1'b1;
        slot_rd_n   = (mode != 1) ? 1'b0 : 1'b1;
    endtask

    task automatic cpu_end();
        @(negedge clk);
        slot_iorq_n = 1'b1;
        slot_rd_n   = 1'b1;
        slot_wr_n   = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus_valid); end
        checks++; if (bus_write !== 1'b0) begin errors++; $display("FAIL rst_write: got %b expected 0", bus_write); end
        checks++; if (bus_address !== 2'd0) begin errors++; $display("FAIL rst_address: got %0d expected 0", bus_address); end
        checks++; if (bus_wdata !== 8'h00) begin errors++; $display("FAIL rst_wdata: got %h expected 00", bus_wdata); end
        checks++; if (slot_d_out !== 8'hFF) begin errors++; $display("FAIL rst_d_out: got %h expected ff", slot_d_out); end
        checks++; if (slot_data_dir !== 1'b0) begin errors++; $display("FAIL rst_dir: got %b expected 0", slot_data_dir); end
        checks++; if (slot_wait !== 1'b0) begin errors++; $display("FAIL rst_wait: got %b expected 0", slot_wait); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write_basic();
        int b_hs, b_p, b_dir;
        cfg_rdly = 0;
        b_hs = hs_q.size(); b_p = pulses; b_dir = dir_cycles;
        cpu_begin(8'h89, 1, 8'h43);
        repeat (2) @(negedge clk);
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL wr_latency_early: got %b expected 0", bus_valid); end
        @(negedge clk);
        checks++;
        if ({bus_valid, bus_write, bus_address, bus_wdata} !== {1'b1, 1'b1, 2'd1, 8'h43}) begin
            errors++; $display("FAIL wr_request: got v%b w%b a%0d d%h expected v1 w1 a1 d43",
                                bus_valid, bus_write, bus_address, bus_wdata);
        end
        repeat (6) @(negedge clk);
        cpu_end();
        checks++; if (hs_q.size() - b_hs !== 1) begin errors++; $display("FAIL wr_hs_count: got %0d expected 1", hs_q.size() - b_hs); end
        checks++; if (pulses - b_p !== 1) begin errors++; $display("FAIL wr_pulses: got %0d expected 1", pulses - b_p); end
        checks++; if (dir_cycles - b_dir !== 0) begin errors++; $display("FAIL wr_dir: got %0d cycles expected 0", dir_cycles - b_dir); end
        if (hs_q.size() > b_hs) begin
            checks++; if (hs_q[b_hs] !== {1'b1, 2'd1, 8'h43}) begin errors++; $display("FAIL wr_hs_fields: got %h expected %h", hs_q[b_hs], {1'b1, 2'd1, 8'h43}); end
        end
    endtask

    task automatic test_write_stall();
        int b_hs, b_vc;
        logic [7:0] wd;
        wd = 8'($urandom);
        cfg_rdly = 10;
        b_hs = hs_q.size(); b_vc = valid_cycles;
        cpu_begin(8'h88, 1, wd);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            checks++;
            if ({bus_valid, bus_write, bus_address, bus_wdata, slot_wait} !== {1'b1, 1'b1, 2'd0, wd, c_wait_en}) begin
                errors++; $display("FAIL stall_cycle%0d: got v%b w%b a%0d d%h wait%b expected v1 w1 a0 d%h wait%b",
                                    i, bus_valid, bus_write, bus_address, bus_wdata, slot_wait, wd, c_wait_en);
            end
            @(negedge clk);
        end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL stall_drop: got %b expected 0", bus_valid); end
        cpu_end();
        checks++; if (valid_cycles - b_vc !== 11) begin errors++; $display("FAIL stall_valid_cycles: got %0d expected 11", valid_cycles - b_vc); end
        checks++; if (hs_q.size() - b_hs !== 1) begin errors++; $display("FAIL stall_hs_count: got %0d expected 1", hs_q.size() - b_hs); end
        cfg_rdly = 0;
    endtask

    task automatic test_read();
        int b_hs;
        cfg_rdly = 0; cfg_ddly = 4; cfg_rdata = 8'h5A;
        b_hs = hs_q.size();
        cpu_begin(8'h8A, 0, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_valid, bus_write, bus_address, slot_data_dir} !== {1'b1, 1'b0, 2'd2, 1'b1}) begin
            errors++; $display("FAIL rd_request: got v%b w%b a%0d dir%b expected v1 w0 a2 dir1",
                                bus_valid, bus_write, bus_address, slot_data_dir);
        end
        repeat (12) @(negedge clk);
        checks++; if (slot_d_out !== 8'h5A) begin errors++; $display("FAIL rd_data: got %h expected 5a", slot_d_out); end
        checks++; if (slot_data_dir !== 1'b1) begin errors++; $display("FAIL rd_dir_hold: got %b expected 1", slot_data_dir); end
        slot_rd_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (slot_data_dir !== 1'b0) begin errors++; $display("FAIL rd_dir_release: got %b expected 0", slot_data_dir); end
        cpu_end();
        checks++; if (hs_q.size() - b_hs !== 1) begin errors++; $display("FAIL rd_hs_count: got %0d expected 1", hs_q.size() - b_hs); end
    endtask

    task automatic test_nonmatch();
        int b_vc, b_dir, b_wait, b_hs;
        b_vc = valid_cycles; b_dir = dir_cycles; b_wait = wait_cycles; b_hs = hs_q.size();
        for (int m = 0; m < 2; m++) begin
            cpu_begin(8'h98, m, 8'h55);
            repeat (10) @(negedge clk);
            cpu_end();
        end
        checks++; if (valid_cycles - b_vc !== 0) begin errors++; $display("FAIL nm_valid: got %0d cycles expected 0", valid_cycles - b_vc); end
        checks++; if (dir_cycles - b_dir !== 0) begin errors++; $display("FAIL nm_dir: got %0d cycles expected 0", dir_cycles - b_dir); end
        checks++; if (wait_cycles - b_wait !== 0) begin errors++; $display("FAIL nm_wait: got %0d cycles expected 0", wait_cycles - b_wait); end
        checks++; if (hs_q.size() - b_hs !== 0) begin errors++; $display("FAIL nm_hs: got %0d expected 0", hs_q.size() - b_hs); end
    endtask

    task automatic test_timeout();
        int b_vc, b_hs;
        cfg_rdly = 100000;
        b_vc = valid_cycles; b_hs = hs_q.size();
        cpu_begin(8'h89, 0, 8'h00);
        repeat (25) @(negedge clk);
        checks++; if (valid_cycles - b_vc !== c_timeout) begin errors++; $display("FAIL tmo_valid_cycles: got %0d expected %0d", valid_cycles - b_vc, c_timeout); end
        checks++; if (slot_d_out !== 8'hFF) begin errors++; $display("FAIL tmo_d_out: got %h expected ff", slot_d_out); end
        checks++; if (slot_wait !== 1'b0) begin errors++; $display("FAIL tmo_wait: got %b expected 0", slot_wait); end
        checks++; if (hs_q.size() - b_hs !== 0) begin errors++; $display("FAIL tmo_hs: got %0d expected 0", hs_q.size() - b_hs); end
        cpu_end();
        cfg_rdly = 0;
    endtask

    task automatic test_reset_midread();
        int b_vc, b_hs;
        logic [7:0] wd;
        cfg_rdly = 0; cfg_ddly = 10; cfg_rdata = 8'hA5;
        b_vc = valid_cycles;
        cpu_begin(8'h89, 0, 8'h00);
        repeat (5) @(negedge clk);
        checks++; if ({bus_valid, slot_data_dir} !== 2'b01) begin errors++; $display("FAIL rw_in_wait: got v%b dir%b expected v0 dir1", bus_valid, slot_data_dir); end
        reset = 1'b1;
        slot_iorq_n = 1'b1; slot_rd_n = 1'b1; slot_wr_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus_valid, bus_write, bus_address, bus_wdata, slot_d_out, slot_data_dir, slot_wait} !==
            {1'b0, 1'b0, 2'd0, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
            errors++; $display("FAIL rw_reset_vals: got v%b w%b a%0d d%h q%h dir%b wait%b expected v0 w0 a0 d00 qff dir0 wait0",
                                bus_valid, bus_write, bus_address, bus_wdata, slot_d_out, slot_data_dir, slot_wait);
        end
        reset = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (valid_cycles - b_vc !== 1) begin errors++; $display("FAIL rw_no_replay: got %0d cycles expected 1", valid_cycles - b_vc); end
        wd = 8'($urandom);
        b_hs = hs_q.size();
        cpu_begin(8'h89, 1, wd);
        repeat (10) @(negedge clk);
        cpu_end();
        checks++; if (hs_q.size() - b_hs !== 1) begin errors++; $display("FAIL rw_after_count: got %0d expected 1", hs_q.size() - b_hs); end
        if (hs_q.size() > b_hs) begin
            checks++; if (hs_q[b_hs] !== {1'b1, 2'd1, wd}) begin errors++; $display("FAIL rw_after_fields: got %h expected %h", hs_q[b_hs], {1'b1, 2'd1, wd}); end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            logic       match;
            logic [7:0] a, d, rdat;
            int         mode, rdly, ddly, exp_vc, b_vc, b_hs;
            logic       exp_hs, exp_wr, exp_dir;
            logic [7:0] exp_dout;
            match = ($urandom % 4) != 0;
            a     = 8'($urandom);
            if (match) a = (c_io_base & 8'hFC) | (a & 8'h03);
            else if ((a & 8'hFC) == (c_io_base & 8'hFC)) a = a ^ 8'h40;
            mode = $urandom % 3;
            d    = 8'($urandom);
            rdly = $urandom % 24;
            ddly = $urandom % 13;
            rdat = 8'($urandom);
            // Expected behaviour of one CPU access, straight from the port-window rules
            exp_wr   = (mode != 0);
            exp_hs   = match && (rdly < c_timeout);
            exp_vc   = !match ? 0 : ((rdly < c_timeout) ? rdly + 1 : c_timeout);
            exp_dir  = match && !exp_wr;
            exp_dout = exp_hs ? rdat : 8'hFF;
            cfg_rdly = rdly; cfg_ddly = ddly; cfg_rdata = rdat;
            b_vc = valid_cycles; b_hs = hs_q.size();
            cpu_begin(a, mode, d);
            repeat (40) @(negedge clk);
            checks++; if (slot_data_dir !== exp_dir) begin errors++; $display("FAIL rnd%0d_dir: got %b expected %b", it, slot_data_dir, exp_dir); end
            if (exp_dir) begin
                checks++; if (slot_d_out !== exp_dout) begin errors++; $display("FAIL rnd%0d_d_out: got %h expected %h", it, slot_d_out, exp_dout); end
            end
            checks++; if (slot_wait !== 1'b0) begin errors++; $display("FAIL rnd%0d_wait: got %b expected 0", it, slot_wait); end
            cpu_end();
            checks++; if (valid_cycles - b_vc !== exp_vc) begin errors++; $display("FAIL rnd%0d_valid_cycles: got %0d expected %0d", it, valid_cycles - b_vc, exp_vc); end
            checks++; if (hs_q.size() - b_hs !== int'(exp_hs)) begin errors++; $display("FAIL rnd%0d_hs_count: got %0d expected %0d", it, hs_q.size() - b_hs, exp_hs); end
            if (exp_hs && hs_q.size() > b_hs) begin
                checks++;
                if (hs_q[b_hs][10:8] !== {exp_wr, a[1:0]} || (exp_wr && hs_q[b_hs][7:0] !== d)) begin
                    errors++; $display("FAIL rnd%0d_hs_fields: got %h expected w%b a%0d d%h", it, hs_q[b_hs], exp_wr, a[1:0], d);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_write_stall();
        test_read();
        test_nonmatch();
        test_timeout();
        test_reset_midread();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
